// File: rtl/collision_scheduler.sv
// collision_scheduler: sequences one collision-analysis pass per trigger.
// Each pass clears the collision block, holds its enable for ANALYZE_CYCLES
// cycles, then snapshots the flags and raises a maskable sticky interrupt.
module collision_scheduler #(
  parameter int FLAG_WIDTH     = 30,
  parameter int ANALYZE_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_auto_en,
  input  logic                  i_frame_tick,
  input  logic                  i_sw_start,
  input  logic [FLAG_WIDTH-1:0] i_flag_mask,
  input  logic                  i_irq_clear,
  input  logic [FLAG_WIDTH-1:0] i_flags_in,
  output logic                  o_coll_enable,
  output logic                  o_coll_reset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [FLAG_WIDTH-1:0] o_flags_snapshot,
  output logic                  o_irq,
  output logic                  o_overrun,
  output logic [7:0]            o_overrun_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ANALYZE_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_done;
  logic [FLAG_WIDTH-1:0]   r_snapshot;
  logic                    r_irq;
  logic                    r_overrun;
  logic [7:0]              r_overrun_cnt;

  logic                    w_trigger;
  logic                    w_capture;
  logic                    w_flag_hit;
  logic                    w_drop;

  // Both trigger sources in one cycle collapse into a single request.
  assign w_trigger  = (i_auto_en & i_frame_tick) | i_sw_start;
  assign w_capture  = (r_state == S_CAPTURE);
  assign w_flag_hit = |(i_flags_in & ~i_flag_mask);
  assign w_drop     = w_trigger & (r_state != S_IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode for the pass sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_next_state = S_CLEAR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_next_state = S_RUN;
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = S_CAPTURE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_CAPTURE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Run counter: zeroed in CLEAR, counts enabled cycles during RUN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == S_CLEAR) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Snapshot and done pulse on the CAPTURE exit edge; flags ignored otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_snapshot <= {FLAG_WIDTH{1'b0}};
      r_done     <= 1'b0;
    end else begin
      r_done <= w_capture;
      if (w_capture) begin
        r_snapshot <= i_flags_in;
      end else begin
        r_snapshot <= r_snapshot;
      end
    end
  end

  // Sticky interrupt; a set on the capture edge takes priority over a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq <= 1'b0;
    end else if (w_capture && w_flag_hit) begin
      r_irq <= 1'b1;
    end else if (i_irq_clear) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq;
    end
  end

  // Dropped-trigger tracking; only reset clears it, counter saturates.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun     <= 1'b0;
      r_overrun_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (r_overrun_cnt != 8'hFF) begin
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end else begin
        r_overrun_cnt <= r_overrun_cnt;
      end
    end else begin
      r_overrun     <= r_overrun;
      r_overrun_cnt <= r_overrun_cnt;
    end
  end

  // coll_reset follows reset combinationally so the block is held clear
  // for as long as reset is asserted; everything else is state-decoded
  // or registered.
  assign o_coll_reset     = i_reset | (r_state == S_CLEAR);
  assign o_coll_enable    = (r_state == S_RUN);
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = r_done;
  assign o_flags_snapshot = r_snapshot;
  assign o_irq            = r_irq;
  assign o_overrun        = r_overrun;
  assign o_overrun_cnt    = r_overrun_cnt;

endmodule
